// File: rtl/step_demo_engine_if.sv
// Pin-side signal bundle of the board self-test engine.
// The engine connects through the slave modport; the board top (or a bench)
// drives the mode/hold controls through the master modport.
interface step_demo_engine_if #(
  parameter int LED_W = 8
);
  logic [1:0]       mode_in;
  logic             hold_in;
  logic             clk_out;
  logic             clk_1Hz;
  logic [LED_W-1:0] Water_led;
  logic [2:0]       Color_led_1;
  logic [2:0]       Color_led_2;
  logic [8:0]       Segment_led_1;
  logic [8:0]       Segment_led_2;

  modport master (
    output mode_in, hold_in,
    input  clk_out, clk_1Hz, Water_led, Color_led_1, Color_led_2,
           Segment_led_1, Segment_led_2
  );

  modport slave (
    input  mode_in, hold_in,
    output clk_out, clk_1Hz, Water_led, Color_led_1, Color_led_2,
           Segment_led_1, Segment_led_2
  );
endinterface

// File: rtl/step_demo_engine.sv
// Board self-test engine: a programmable divider produces a slow tick that
// steps a water-LED pattern (four modes), a two-digit BCD counter on two
// 7-segment digits and a pair of complementary RGB colour sequencers.
//
// Optional feature macro: STEP_DEMO_KEY_DEBOUNCE_EN
//   defined   - hold_in is an active-low push key; it is synchronised and
//               debounced, and each debounced press toggles the freeze state.
//               The units decimal point shows the freeze state.
//   undefined - hold_in is an active-high level, only synchronised.
//
// Parameter limits: CLK_FREQ/TICK_HZ >= 2, LED_W >= 2, DEB_CYCLES >= 1.
module step_demo_engine #(
  parameter int CLK_FREQ       = 25_000_000,
  parameter int TICK_HZ        = 1,
  parameter int LED_W          = 8,
  parameter bit LED_ACTIVE_LOW = 1'b1,
  parameter int DEB_CYCLES     = 500_000
) (
  input logic               clk_in,
  input logic               rst_n_in,
  step_demo_engine_if.slave bus
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

  localparam logic [LED_W-1:0] PAT_ONE    = LED_W'(1);
  localparam logic [LED_W-1:0] WATER_INV  = {LED_W{LED_ACTIVE_LOW}};
  localparam logic [2:0]       COLOUR_INV = {3{LED_ACTIVE_LOW}};

  localparam logic [2:0] COLOUR_RST = 3'b001;
  localparam logic [6:0] SEG_ZERO   = 7'h3F;

  typedef enum logic [1:0] {
    MODE_ROL   = 2'b00,
    MODE_ROR   = 2'b01,
    MODE_PING  = 2'b10,
    MODE_COUNT = 2'b11
  } water_mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Out-of-range parameters stop elaboration instead of building a broken core.
  if (DIV < 2 || LED_W < 2 || DEB_CYCLES < 1) begin : g_bad_params
    $error("step_demo_engine: illegal parameter set");
  end

  // 7-segment encoding, active-high, bit order GFEDCBA.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Colour A walks the seven non-zero codes; 000 is never visited, so the
  // complementary colour B never shows 111.
  function automatic logic [2:0] colour_step(input logic [2:0] c);
    case (c)
      3'b001:  colour_step = 3'b010;
      3'b010:  colour_step = 3'b100;
      3'b100:  colour_step = 3'b011;
      3'b011:  colour_step = 3'b110;
      3'b110:  colour_step = 3'b101;
      3'b101:  colour_step = 3'b111;
      3'b111:  colour_step = 3'b001;
      default: colour_step = COLOUR_RST;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] div_cnt;
  logic             tick_q;
  logic             clk_1hz_q;

  // Free-running divider; the tick is registered so clk_out is glitch-free at
  // the pin, and it is high exactly while the count sits at DIV-1.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers sample the pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt   <= '0;
      tick_q    <= 1'b0;
      clk_1hz_q <= 1'b0;
    end else begin
      if (div_cnt == CNT_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      tick_q <= (div_cnt == CNT_PRE);
      if (tick_q) begin
        clk_1hz_q <= ~clk_1hz_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hold / freeze path
  // ---------------------------------------------------------------------------
  logic hold_meta;
  logic hold_sync;
  logic frozen;
  logic dp_units;

`ifdef STEP_DEMO_KEY_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt;
  logic             key_level;
  logic             frozen_q;

  // Two-stage synchroniser; it idles high because the raw key is active-low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hold_meta <= 1'b1;
      hold_sync <= 1'b1;
    end else begin
      hold_meta <= bus.hold_in;
      hold_sync <= hold_meta;
    end
  end

  // A new key level is accepted only after DEB_CYCLES unchanged clocks;
  // every accepted press (high-to-low) toggles the freeze state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      deb_cnt   <= '0;
      key_level <= 1'b1;
      frozen_q  <= 1'b0;
    end else if (hold_sync == key_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt   <= '0;
      key_level <= hold_sync;
      if (!hold_sync) begin
        frozen_q <= ~frozen_q;
      end
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign frozen   = frozen_q;
  assign dp_units = frozen_q;
`else
  // Two-stage synchroniser; the synchronised level is the freeze request.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hold_meta <= 1'b0;
      hold_sync <= 1'b0;
    end else begin
      hold_meta <= bus.hold_in;
      hold_sync <= hold_meta;
    end
  end

  assign frozen   = hold_sync;
  assign dp_units = 1'b0;
`endif

  // A tick advances the display state only while not frozen; a freeze that
  // is already registered wins over a coincident tick.
  logic advance;
  assign advance = tick_q & ~frozen;

  // ---------------------------------------------------------------------------
  // Water-LED pattern
  // ---------------------------------------------------------------------------
  logic [LED_W-1:0] pattern;
  logic [LED_W-1:0] pattern_nxt;
  dir_e             dir;
  dir_e             dir_nxt;
  logic             is_onehot;

  assign is_onehot = (pattern != '0) && ((pattern & (pattern - 1'b1)) == '0);

  // Next pattern for the selected mode; shift modes restart from a single
  // LSB whenever the counting mode has left a non-one-hot value behind.
  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    pattern_nxt = pattern;
    dir_nxt     = dir;
    case (water_mode_e'(bus.mode_in))
      MODE_ROL: begin
        pattern_nxt = is_onehot ? {pattern[LED_W-2:0], pattern[LED_W-1]} : PAT_ONE;
      end
      MODE_ROR: begin
        pattern_nxt = is_onehot ? {pattern[0], pattern[LED_W-1:1]} : PAT_ONE;
      end
      MODE_PING: begin
        if (!is_onehot) begin
          pattern_nxt = PAT_ONE;
          dir_nxt     = DIR_LEFT;
        end else if ((dir == DIR_LEFT && !pattern[LED_W-1]) ||
                     (dir == DIR_RIGHT && pattern[0])) begin
          // Flip direction in the same step the hot bit lands on an end.
          pattern_nxt = pattern << 1;
          dir_nxt     = pattern[LED_W-2] ? DIR_RIGHT : DIR_LEFT;
        end else begin
          pattern_nxt = pattern >> 1;
          dir_nxt     = pattern[1] ? DIR_LEFT : DIR_RIGHT;
        end
      end
      MODE_COUNT: begin
        pattern_nxt = pattern + 1'b1;
      end
      default: begin
        pattern_nxt = PAT_ONE;
      end
    endcase
  end

  // Pattern and ping-pong direction registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pattern <= PAT_ONE;
      dir     <= DIR_LEFT;
    end else if (advance) begin
      pattern <= pattern_nxt;
      dir     <= dir_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // BCD counter and segment drivers
  // ---------------------------------------------------------------------------
  logic [3:0] units;
  logic [3:0] tens;
  logic [8:0] seg_tens;
  logic [8:0] seg_units;

  // Two-digit decimal count; 99 rolls over to 00.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      units <= 4'd0;
      tens  <= 4'd0;
    end else if (advance) begin
      if (units == 4'd9) begin
        units <= 4'd0;
        tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

  // Registered segment outputs (S, P, GFEDCBA), one clock behind the count.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      seg_tens  <= {2'b00, SEG_ZERO};
      seg_units <= {2'b00, SEG_ZERO};
    end else begin
      seg_tens  <= {1'b0, 1'b0, seg7(tens)};
      seg_units <= {1'b0, dp_units, seg7(units)};
    end
  end

  // ---------------------------------------------------------------------------
  // Colour sequencer
  // ---------------------------------------------------------------------------
  logic [2:0] colour_a;

  // Colour A steps once per advance; colour B is derived as its complement.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      colour_a <= COLOUR_RST;
    end else if (advance) begin
      colour_a <= colour_step(colour_a);
    end
  end

  // ---------------------------------------------------------------------------
  // Pin drivers
  // ---------------------------------------------------------------------------
  assign bus.clk_out       = tick_q;
  assign bus.clk_1Hz       = clk_1hz_q;
  assign bus.Water_led     = pattern ^ WATER_INV;
  assign bus.Color_led_1   = colour_a ^ COLOUR_INV;
  assign bus.Color_led_2   = ~colour_a ^ COLOUR_INV;
  assign bus.Segment_led_1 = seg_tens;
  assign bus.Segment_led_2 = seg_units;

endmodule

// File: tb/tb_step_demo_engine.sv
// Directed bench for step_demo_engine: DIV = 100/10 = 10 clocks per tick,
// 8 water LEDs, active-low LED pins, default (non-debounce) hold path.
module tb_step_demo_engine;

  localparam int CLK_FREQ = 100;
  localparam int TICK_HZ  = 10;
  localparam int LED_W    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  step_demo_engine_if #(.LED_W(LED_W)) bus ();

  step_demo_engine #(
    .CLK_FREQ      (CLK_FREQ),
    .TICK_HZ       (TICK_HZ),
    .LED_W         (LED_W),
    .LED_ACTIVE_LOW(1'b1),
    .DEB_CYCLES    (4)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Active-low pin value of an internal water pattern.
  function automatic logic [31:0] wpin(input logic [7:0] p);
    return {24'h0, ~p};
  endfunction

  // Active-low pin value of a colour code.
  function automatic logic [31:0] cpin(input logic [2:0] c);
    return {29'h0, ~c};
  endfunction

  // Colour A after k advances from reset.
  function automatic logic [2:0] colour_a(input int k);
    case (k % 7)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b100;
      3:       return 3'b011;
      4:       return 3'b110;
      5:       return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  // Segment word (S=0, P=0, GFEDCBA) for a digit.
  function automatic logic [31:0] segw(input int d);
    case (d)
      0:       return 32'h03F;
      1:       return 32'h006;
      2:       return 32'h05B;
      3:       return 32'h04F;
      4:       return 32'h066;
      5:       return 32'h06D;
      6:       return 32'h07D;
      7:       return 32'h007;
      8:       return 32'h07F;
      default: return 32'h06F;
    endcase
  endfunction

  // Waits for a clk_out pulse (sampled on the falling edge), then one more
  // falling edge so the advancing rising edge has passed. cyc = falling
  // edges spent waiting.
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.clk_out !== 1'b1 && cyc < 40);
    if (bus.clk_out !== 1'b1) check("tick_timeout", 32'(bus.clk_out), 32'h1);
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    int c;
    for (int i = 0; i < n; i++) wait_tick(c);
  endtask

  logic [7:0] pp_seq [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  initial begin
    int cyc;
    bus.mode_in = 2'b00;
    bus.hold_in = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_water",  32'(bus.Water_led),     32'h0FE);
    check("rst_color1", 32'(bus.Color_led_1),   32'h6);
    check("rst_color2", 32'(bus.Color_led_2),   32'h1);
    check("rst_seg1",   32'(bus.Segment_led_1), 32'h03F);
    check("rst_seg2",   32'(bus.Segment_led_2), 32'h03F);
    check("rst_clkout", 32'(bus.clk_out),       32'h0);
    check("rst_clk1hz", 32'(bus.clk_1Hz),       32'h0);
    rst_n = 1'b1;

    // Rotate-left, ticks 1..8 (pattern 01 -> 02 -> ... -> 80 -> 01).
    wait_tick(cyc);
    check("rol_t1",       32'(bus.Water_led), wpin(8'h02));
    check("clkout_width", 32'(bus.clk_out),   32'h0);
    check("clk1hz_t1",    32'(bus.clk_1Hz),   32'h1);
    wait_tick(cyc);
    check("tick_period", 32'(cyc + 1), 32'd10);
    check("clk1hz_t2",   32'(bus.clk_1Hz), 32'h0);
    for (int k = 3; k <= 8; k++) begin
      wait_tick(cyc);
      check("color1", 32'(bus.Color_led_1), cpin(colour_a(k)));
      check("color2", 32'(bus.Color_led_2), {29'h0, colour_a(k)});
      if (k == 3) check("rol_t3",     32'(bus.Water_led),   32'h0F7);
      if (k == 7) check("color_wrap", 32'(bus.Color_led_1), 32'h6);
      if (k == 8) check("rol_t8",     32'(bus.Water_led),   32'h0FE);
    end

    // Ping-pong from 01, direction left: no repeat at either end.
    bus.mode_in = 2'b10;
    for (int i = 0; i < 16; i++) begin
      wait_tick(cyc);
      check("pingpong", 32'(bus.Water_led), wpin(pp_seq[i]));
    end
    // 24 advances: segments still show 23 right after the edge, then 24.
    check("seg_lat_tens",  32'(bus.Segment_led_1), segw(2));
    check("seg_lat_units", 32'(bus.Segment_led_2), segw(3));
    @(negedge clk);
    check("seg_24_units",  32'(bus.Segment_led_2), segw(4));

    // Asynchronous reset in the middle of a tick period.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_water",  32'(bus.Water_led),     32'h0FE);
    check("arst_color1", 32'(bus.Color_led_1),   32'h6);
    check("arst_color2", 32'(bus.Color_led_2),   32'h1);
    check("arst_seg1",   32'(bus.Segment_led_1), 32'h03F);
    check("arst_seg2",   32'(bus.Segment_led_2), 32'h03F);
    check("arst_clkout", 32'(bus.clk_out),       32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Binary count from 01: 5 ticks -> 06, 254 ticks -> FF, then 00.
    bus.mode_in = 2'b11;
    run_ticks(5);
    check("cnt_06", 32'(bus.Water_led), wpin(8'h06));
    run_ticks(249);
    check("cnt_ff", 32'(bus.Water_led), wpin(8'hFF));
    wait_tick(cyc);
    check("cnt_wrap", 32'(bus.Water_led), wpin(8'h00));
    // Leaving count mode with a non-one-hot value restarts at 01.
    bus.mode_in = 2'b00;
    wait_tick(cyc);
    check("cnt_to_rol", 32'(bus.Water_led), wpin(8'h01));

    // 256 advances so far (BCD 56); 43 more reach 99.
    run_ticks(42);
    wait_tick(cyc);
    check("bcd98_tens",  32'(bus.Segment_led_1), segw(9));
    check("bcd98_units", 32'(bus.Segment_led_2), segw(8));
    @(negedge clk);
    check("bcd99_tens",  32'(bus.Segment_led_1), segw(9));
    check("bcd99_units", 32'(bus.Segment_led_2), segw(9));
    wait_tick(cyc);
    check("bcd_lat_units", 32'(bus.Segment_led_2), segw(9));
    @(negedge clk);
    check("bcd00_tens",  32'(bus.Segment_led_1), segw(0));
    check("bcd00_units", 32'(bus.Segment_led_2), segw(0));
    // 300 advances: pattern 01 rotated 44 times = 10, colour A = 111.
    check("rol_300",    32'(bus.Water_led),   wpin(8'h10));
    check("color1_300", 32'(bus.Color_led_1), cpin(3'b111));
    check("color2_300", 32'(bus.Color_led_2), 32'h7);

    // Hold for 5 ticks: display frozen, divider and square wave keep going.
    bus.hold_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_tick(cyc);
      check("hold_water",  32'(bus.Water_led),     wpin(8'h10));
      check("hold_color1", 32'(bus.Color_led_1),   cpin(3'b111));
      check("hold_seg2",   32'(bus.Segment_led_2), segw(0));
    end
    check("hold_clk1hz", 32'(bus.clk_1Hz), 32'h1);

    // Release: the next tick advances again.
    bus.hold_in = 1'b0;
    wait_tick(cyc);
    check("rel_water",  32'(bus.Water_led),   wpin(8'h20));
    check("rel_color1", 32'(bus.Color_led_1), cpin(3'b001));
    @(negedge clk);
    check("rel_seg1", 32'(bus.Segment_led_1), segw(0));
    check("rel_seg2", 32'(bus.Segment_led_2), segw(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit in case a bounded wait is somehow bypassed.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
